zl_uart_rx_fifo: RTL and testbench

//  Parametrised successor to the single-rate zl_uart receiver.
//  - Recovers serial frames from rx with a configurable bit period, data width, bit order and parity.
//  - Pushes good frames into a first-word-fall-through FIFO, drained by a valid/ready handshake.
//  - Sits between the io_in rx pin and the command decoder; optional hex display of the last byte.

---
 rtl/zl_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_zl_uart_rx_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zl_uart_rx_fifo.sv
// zl_uart_rx_fifo: UART receiver with configurable bit period, width, bit order and parity.
// Good frames go to a first-word-fall-through FIFO. Define ZL_UART_SEG7_EN for a hex display of the last frame.
module zl_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_rx,
  output logic [DATA_BITS-1:0]               o_out_data,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_level,
  output logic                               o_busy,
  output logic                               o_frame_err,
  output logic                               o_parity_err,
  output logic                               o_overrun_err,
  output logic [6:0]                         o_segments
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = $clog2(DATA_BITS);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  logic                 r_rx_meta, r_rx_s;
  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next, w_cnt_inc;
  logic [BW-1:0]        r_bit_idx, w_bit_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_par_bit, w_par_next;
  logic                 w_sample, w_bit_end, w_par_bad;
  logic                 w_push, w_fe, w_pe;
  logic                 r_frame_err, r_parity_err, r_overrun_err;

  // Synchroniser presets high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_sample  = (r_cnt == C_HALF);
  assign w_bit_end = (r_cnt == C_LAST);
  assign w_cnt_inc = w_bit_end ? '0 : r_cnt + CW'(1);
  assign w_par_bad = (PARITY != 0) && (r_par_bit != ((^r_shift) ^ (PARITY == 2)));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_par_next   = r_par_bit;
    w_push       = 1'b0;
    w_fe         = 1'b0;
    w_pe         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          // The detecting clock is offset 0; with one clock per bit it is also the start sample.
          w_bit_next = '0;
          if (CLKS_PER_BIT == 1) begin
            w_state_next = S_DATA;
            w_cnt_next   = '0;
          end else begin
            w_state_next = S_START;
            w_cnt_next   = CW'(1);
          end
        end
      end
      S_START: begin
        w_cnt_next = w_cnt_inc;
        if (w_sample && r_rx_s) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_bit_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_cnt_next = w_cnt_inc;
        if (w_sample)
          w_shift_next = (MSB_FIRST != 0) ? {r_shift[DATA_BITS-2:0], r_rx_s}
                                          : {r_rx_s, r_shift[DATA_BITS-1:1]};
        if (w_bit_end) begin
          w_bit_next = r_bit_idx + BW'(1);
          if (r_bit_idx == B_LAST)
            w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_cnt_next = w_cnt_inc;
        if (w_sample)
          w_par_next = r_rx_s;
        if (w_bit_end)
          w_state_next = S_STOP;
      end
      S_STOP: begin
        w_cnt_next = w_cnt_inc;
        if (w_sample) begin
          w_cnt_next = '0;
          if (!r_rx_s) begin
            w_fe         = 1'b1;
            w_state_next = S_BREAK;
          end else if (w_par_bad) begin
            w_pe         = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_push       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        w_cnt_next = '0;
        if (r_rx_s)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_par_bit <= w_par_next;
    end
  end

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 w_full, w_pop, w_wr_en, w_ovr;

  // A full FIFO still accepts a frame when the head leaves on the same edge.
  assign w_full  = (r_level == L_FULL);
  assign w_pop   = (r_level != '0) && i_out_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_ovr   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      r_frame_err   <= w_fe;
      r_parity_err  <= w_pe;
      r_overrun_err <= w_ovr;
    end
  end

  assign o_out_valid   = (r_level != '0);
  assign o_out_data    = o_out_valid ? r_mem[r_rd_ptr] : '0;
  assign o_fifo_level  = r_level;
  assign o_busy        = (r_state != S_IDLE);
  assign o_frame_err   = r_frame_err;
  assign o_parity_err  = r_parity_err;
  assign o_overrun_err = r_overrun_err;

`ifdef ZL_UART_SEG7_EN
  logic [6:0] r_seg, w_seg_dec;

  always_comb begin
    w_seg_dec = 7'h00;
    case (r_shift[3:0])
      4'h0: w_seg_dec = 7'h3F;
      4'h1: w_seg_dec = 7'h06;
      4'h2: w_seg_dec = 7'h5B;
      4'h3: w_seg_dec = 7'h4F;
      4'h4: w_seg_dec = 7'h66;
      4'h5: w_seg_dec = 7'h6D;
      4'h6: w_seg_dec = 7'h7D;
      4'h7: w_seg_dec = 7'h07;
      4'h8: w_seg_dec = 7'h7F;
      4'h9: w_seg_dec = 7'h6F;
      4'hA: w_seg_dec = 7'h77;
      4'hB: w_seg_dec = 7'h7C;
      4'hC: w_seg_dec = 7'h39;
      4'hD: w_seg_dec = 7'h5E;
      4'hE: w_seg_dec = 7'h79;
      default: w_seg_dec = 7'h71;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_seg <= 7'h00;
    else if (w_wr_en)
      r_seg <= w_seg_dec;
  end

  assign o_segments = r_seg;
`else
  assign o_segments = 7'b0000000;
`endif

endmodule

// File: tb/tb_zl_uart_rx_fifo.sv
// Bench for zl_uart_rx_fifo: instance A uses the defaults, instance B runs 4 clk/bit, LSB first, even parity.
// Vector table, hand-written corner sequences, and a randomized run against a queue model.
`timescale 1ns/1ps
module tb_zl_uart_rx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_a, rdy_a, rx_b, rdy_b;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b, busy_a, busy_b;
  logic [2:0] lvl_a, lvl_b;
  logic       fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
  logic [6:0] seg_a, seg_b;

  zl_uart_rx_fifo #(.CLKS_PER_BIT(1), .DATA_BITS(8), .MSB_FIRST(1), .PARITY(0), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_a), .o_out_data(data_a), .o_out_valid(val_a),
    .i_out_ready(rdy_a), .o_fifo_level(lvl_a), .o_busy(busy_a), .o_frame_err(fe_a),
    .o_parity_err(pe_a), .o_overrun_err(ov_a), .o_segments(seg_a));

  zl_uart_rx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .MSB_FIRST(0), .PARITY(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_b), .o_out_data(data_b), .o_out_valid(val_b),
    .i_out_ready(rdy_b), .o_fifo_level(lvl_b), .o_busy(busy_b), .o_frame_err(fe_b),
    .o_parity_err(pe_b), .o_overrun_err(ov_b), .o_segments(seg_b));

`ifdef ZL_UART_SEG7_EN
  localparam bit SEG_EN = 1'b1;
`else
  localparam bit SEG_EN = 1'b0;
`endif

  typedef struct {
    bit         b;
    logic [7:0] data;
    bit         par;
    bit         stop;
    bit         exp_push;
    bit         exp_fe;
    bit         exp_pe;
  } vec_t;

  int         n_pass = 0, n_total = 0;
  int         exp_fe[2], exp_pe[2], exp_ov[2];
  int         mon_fe[2], mon_pe[2], mon_ov[2];
  logic [7:0] qa[$], qb[$];
  logic [7:0] last_push[2];
  bit         have_push[2];
  vec_t       vecs[14];

  // Pulse counters; a stretched or duplicated pulse shows up as an extra count.
  always @(negedge clk) begin
    if (fe_a) mon_fe[0]++;
    if (pe_a) mon_pe[0]++;
    if (ov_a) mon_ov[0]++;
    if (fe_b) mon_fe[1]++;
    if (pe_b) mon_pe[1]++;
    if (ov_b) mon_ov[1]++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input bit b, input logic v);
    if (b) rx_b = v; else rx_a = v;
  endtask

  task automatic idle(input bit b, input int n);
    set_rx(b, 1'b1);
    tick(n);
  endtask

  // Start bit, data bits in the instance's bit order, parity (B only), stop bit; rx is left at the stop value.
  task automatic send_frame(input bit b, input logic [7:0] d, input bit par, input bit stop);
    logic fb[$];
    int   cpb = b ? 4 : 1;
    fb.push_back(1'b0);
    for (int i = 0; i < 8; i++) fb.push_back(b ? d[i] : d[7-i]);
    if (b) fb.push_back(par);
    fb.push_back(stop);
    foreach (fb[k]) begin
      set_rx(b, fb[k]);
      tick(cpb);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic logic [6:0] seg_exp(input bit b);
    return (SEG_EN && have_push[b]) ? hex7(last_push[b][3:0]) : 7'h00;
  endfunction

  task automatic model_push(input bit b, input logic [7:0] d);
    int sz = b ? qb.size() : qa.size();
    if (sz < 4) begin
      if (b) qb.push_back(d); else qa.push_back(d);
      last_push[b] = d;
      have_push[b] = 1'b1;
    end else begin
      exp_ov[b]++;
    end
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_fe%0d", tag, i), 32'(mon_fe[i]), 32'(exp_fe[i]));
      check($sformatf("%s_pe%0d", tag, i), 32'(mon_pe[i]), 32'(exp_pe[i]));
      check($sformatf("%s_ov%0d", tag, i), 32'(mon_ov[i]), 32'(exp_ov[i]));
    end
  endtask

  task automatic check_state(input bit b, input string tag);
    int         sz;
    logic [7:0] head;
    sz   = b ? qb.size() : qa.size();
    head = (sz == 0) ? 8'h00 : (b ? qb[0] : qa[0]);
    check({tag, "_level"}, 32'(b ? lvl_b : lvl_a), 32'(sz));
    check({tag, "_valid"}, 32'(b ? val_b : val_a), 32'(sz != 0));
    check({tag, "_data"},  32'(b ? data_b : data_a), 32'(head));
    check({tag, "_busy"},  32'(b ? busy_b : busy_a), 32'(0));
    check({tag, "_seg"},   32'(b ? seg_b : seg_a), 32'(seg_exp(b)));
  endtask

  task automatic pop_one(input bit b, input string tag);
    logic [7:0] e;
    if (b) e = qb.pop_front(); else e = qa.pop_front();
    check({tag, "_pop_valid"}, 32'(b ? val_b : val_a), 32'(1));
    check({tag, "_pop_data"},  32'(b ? data_b : data_a), 32'(e));
    if (b) rdy_b = 1'b1; else rdy_a = 1'b1;
    tick(1);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  task automatic drain(input bit b, input string tag);
    while ((b ? qb.size() : qa.size()) > 0) pop_one(b, tag);
    check_state(b, {tag, "_drained"});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'({val_a, data_a, lvl_a, busy_a, fe_a, pe_a, ov_a, seg_a}), 32'(0));
    check({tag, "_b"}, 32'({val_b, data_b, lvl_b, busy_b, fe_b, pe_b, ov_b, seg_b}), 32'(0));
  endtask

  initial begin
    vec_t       v;
    int         cpb, nf, npop;
    logic [7:0] d;
    bit         bad;

    //          b     data   par   stop  push  fe    pe
    vecs[0]  = '{1'b0, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(3);
    check_state(0, "post_reset_a");
    check_state(1, "post_reset_b");

    // Ready while empty must not disturb the FIFO.
    rdy_a = 1'b1;
    tick(4);
    check_state(0, "empty_ready");
    rdy_a = 1'b0;

    // Single frame 0x08 with exact push latency.
    send_frame(0, 8'h08, 1'b0, 1'b1);
    check("t1_busy_data", 32'(busy_a), 32'(1));
    tick(1);
    check("t1_valid_before", 32'(val_a), 32'(0));
    tick(1);
    model_push(0, 8'h08);
    check_state(0, "t1");
    check_counts("t1");
    drain(0, "t1");

    // Five back-to-back frames overrun a 4-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(0, d, 1'b0, 1'b1);
      model_push(0, d);
    end
    idle(0, 4);
    check_state(0, "t2");
    check_counts("t2");
    drain(0, "t2");

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      d = 8'h11 + 8'(i);
      send_frame(0, d, 1'b0, 1'b1);
      model_push(0, d);
    end
    idle(0, 3);
    check_state(0, "full");
    send_frame(0, 8'h55, 1'b0, 1'b1);
    tick(1);
    check("full_head", 32'(data_a), 32'(qa[0]));
    rdy_a = 1'b1;
    tick(1);
    rdy_a = 1'b0;
    d = qa.pop_front();
    model_push(0, 8'h55);
    check_state(0, "full_pushpop");
    check_counts("full_pushpop");
    drain(0, "full_pushpop");

    // Framing error holds busy until rx returns high.
    send_frame(0, 8'h08, 1'b0, 1'b0);
    tick(5);
    exp_fe[0]++;
    check("t3_break_busy", 32'(busy_a), 32'(1));
    check("t3_level", 32'(lvl_a), 32'(0));
    check_counts("t3");
    idle(0, 4);
    check_state(0, "t3_idle");

    for (int i = 0; i < 14; i++) begin
      v   = vecs[i];
      cpb = v.b ? 4 : 1;
      send_frame(v.b, v.data, v.par, v.stop);
      if (!v.stop) tick(3 * cpb);
      idle(v.b, 4 * cpb + 4);
      if (v.exp_push) model_push(v.b, v.data);
      if (v.exp_fe) exp_fe[v.b]++;
      if (v.exp_pe) exp_pe[v.b]++;
      check_state(v.b, $sformatf("vec%0d", i));
      check_counts($sformatf("vec%0d", i));
      drain(v.b, $sformatf("vec%0d", i));
    end

    // One-clock low glitch on the slow instance: start seen, rejected at mid-bit.
    rx_b = 1'b0;
    tick(1);
    rx_b = 1'b1;
    tick(2);
    check("glitch_start_seen", 32'(busy_b), 32'(1));
    tick(10);
    check_state(1, "glitch");
    check_counts("glitch");

    for (int r = 0; r < 25; r++) begin
      nf = int'($urandom_range(6, 1));
      for (int f = 0; f < nf; f++) begin
        d   = 8'($urandom);
        bad = ($urandom_range(5, 0) == 0);
        send_frame(0, d, 1'b0, !bad);
        if (bad) begin
          tick(int'($urandom_range(3, 1)));
          idle(0, 2);
          exp_fe[0]++;
        end else begin
          model_push(0, d);
          if ($urandom_range(1, 0) == 1) idle(0, int'($urandom_range(3, 1)));
        end
      end
      idle(0, 4);
      check_state(0, $sformatf("rand%0d", r));
      check_counts($sformatf("rand%0d", r));
      npop = int'($urandom_range(32'(qa.size()), 0));
      repeat (npop) pop_one(0, $sformatf("rand%0d", r));
    end
    drain(0, "rand_end");

    // Reset in the middle of a frame with a word held in the FIFO.
    send_frame(0, 8'h11, 1'b0, 1'b1);
    model_push(0, 8'h11);
    idle(0, 3);
    rx_a = 1'b0;
    tick(1);
    rx_a = 1'b1;
    tick(3);
    check("midrst_busy_pre", 32'(busy_a), 32'(1));
    check("midrst_valid_pre", 32'(val_a), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    qa.delete();
    qb.delete();
    have_push[0] = 1'b0;
    have_push[1] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_frame(0, 8'hC3, 1'b0, 1'b1);
    idle(0, 4);
    model_push(0, 8'hC3);
    check_state(0, "after_rst");
    check_counts("after_rst");
    drain(0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
